// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: feeds one nibble pair per cycle
// to a shared 4x4 multiplier and shift-accumulates the four partial products.
module mul8_seq_ctrl #(
  parameter int ZERO_SKIP = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic SKIP_EN = (ZERO_SKIP != 0);

  logic [1:0]       state_reg, state_next;
  logic [1:0]       step_reg, step_next;
  logic [7:0]       a_reg, a_next;
  logic [7:0]       b_reg, b_next;
  logic [15:0]      acc_reg, acc_next;
  logic [15:0]      out_p_reg, out_p_next;
  logic [CNT_W-1:0] op_count_reg, op_count_next;

  logic [15:0] pp_shift;
  logic [15:0] acc_sum;
  logic        accept;
  logic        zero_op;

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_p     = out_p_reg;
  assign op_count  = op_count_reg;

  assign accept  = in_valid && in_ready;
  assign zero_op = SKIP_EN && ((in_a == 8'h00) || (in_b == 8'h00));

  // Nibble selection for the shared multiplier; the bus is parked at zero outside CALC.
  always_comb begin
    mul_a = 4'h0;
    mul_b = 4'h0;
    if (state_reg == CALC) begin
      case (step_reg)
        2'd0: begin mul_a = a_reg[3:0]; mul_b = b_reg[3:0]; end
        2'd1: begin mul_a = a_reg[7:4]; mul_b = b_reg[3:0]; end
        2'd2: begin mul_a = a_reg[3:0]; mul_b = b_reg[7:4]; end
        default: begin mul_a = a_reg[7:4]; mul_b = b_reg[7:4]; end
      endcase
    end
  end

  // Cross terms (steps 1 and 2) share the same weight of 2^4.
  always_comb begin
    pp_shift = 16'h0000;
    case (step_reg)
      2'd0:    pp_shift = {8'h00, mul_p};
      2'd1:    pp_shift = {4'h0, mul_p, 4'h0};
      2'd2:    pp_shift = {4'h0, mul_p, 4'h0};
      default: pp_shift = {mul_p, 8'h00};
    endcase
  end

  assign acc_sum = acc_reg + pp_shift;

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    acc_next      = acc_reg;
    out_p_next    = out_p_reg;
    op_count_next = op_count_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next   = in_a;
          b_next   = in_b;
          acc_next = 16'h0000;
          if (zero_op) begin
            out_p_next = 16'h0000;
            state_next = DONE;
          end else begin
            step_next  = 2'd0;
            state_next = CALC;
          end
        end
      end

      CALC: begin
        acc_next  = acc_sum;
        step_next = step_reg + 2'd1;
        if (step_reg == 2'd3) begin
          out_p_next = acc_sum;
          state_next = DONE;
        end
      end

      DONE: begin
        // Result and valid hold indefinitely until the consumer takes it.
        if (out_ready) begin
          op_count_next = op_count_reg + 1'b1;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      step_reg     <= 2'd0;
      a_reg        <= 8'h00;
      b_reg        <= 8'h00;
      acc_reg      <= 16'h0000;
      out_p_reg    <= 16'h0000;
      op_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      acc_reg      <= acc_next;
      out_p_reg    <= out_p_next;
      op_count_reg <= op_count_next;
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Scoreboard bench for mul8_seq_ctrl: three instances cover zero-skip on/off and
// a narrow wrapping counter; a negedge monitor checks every accepted result.
module tb_mul8_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        bsy  [3];
  logic [7:0]  ia   [3];
  logic [7:0]  ib   [3];
  logic [7:0]  mp   [3];
  logic [3:0]  ma   [3];
  logic [3:0]  mb   [3];
  logic [15:0] op   [3];
  logic [15:0] oc0, oc1;
  logic [3:0]  oc2;

  // Behavioural stand-in for the external 4x4 multiplier.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mul
    assign mp[gi] = {4'h0, ma[gi]} * {4'h0, mb[gi]};
  end

  mul8_seq_ctrl #(.ZERO_SKIP(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_p(op[0]), .busy(bsy[0]), .op_count(oc0));

  mul8_seq_ctrl #(.ZERO_SKIP(0), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
    .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_p(op[1]), .busy(bsy[1]), .op_count(oc1));

  mul8_seq_ctrl #(.ZERO_SKIP(1), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
    .mul_a(ma[2]), .mul_b(mb[2]), .mul_p(mp[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_p(op[2]), .busy(bsy[2]), .op_count(oc2));

  typedef struct {
    int          dut;
    logic [15:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    if (d == 0) return {16'h0, oc0};
    if (d == 1) return {16'h0, oc1};
    return {28'h0, oc2};
  endfunction

  function automatic logic [31:0] cnt_mask(input int d, input int v);
    if (d == 2) return v & 32'hF;
    return v & 32'hFFFF;
  endfunction

  function automatic logic [3:0] exp_ma(input logic [7:0] a, input int s);
    return (s == 0 || s == 2) ? a[3:0] : a[7:4];
  endfunction

  function automatic logic [3:0] exp_mb(input logic [7:0] b, input int s);
    return (s < 2) ? b[3:0] : b[7:4];
  endfunction

  // Monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && ordy[d]) begin
          if (sb.size() == 0 || sb[0].dut != d) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output dut=%0d actual=%0h required=none", d, op[d]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("out_p_d%0d", d), {16'h0, op[d]}, {16'h0, e.p});
            $display("txn dut=%0d out_p=%04h", d, op[d]);
          end
        end
      end
    end
  end

  // Issue one operation; called just after a rising edge.
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input int lat, input logic stall);
    int n;
    int to;
    exp_t e;
    to = 0;
    while (!ir[d] && to < 50) begin
      @(posedge clk); #1;
      to++;
    end
    check($sformatf("ready_wait_d%0d", d), {31'h0, ir[d]}, 32'h1);
    if (stall) ordy[d] = 1'b0;
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    e.dut = d;
    e.p   = p;
    sb.push_back(e);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    ia[d] = 8'hC3;
    ib[d] = 8'h3C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ov[d] && n <= 4) begin
        check($sformatf("mul_a_d%0d_s%0d", d, n - 1), {28'h0, ma[d]}, {28'h0, exp_ma(a, n - 1)});
        check($sformatf("mul_b_d%0d_s%0d", d, n - 1), {28'h0, mb[d]}, {28'h0, exp_mb(b, n - 1)});
      end
    end while (!ov[d] && n < 20);
    check($sformatf("latency_d%0d", d), n, lat);
    if (lat == 1) begin
      check("skip_mul_a", {28'h0, ma[d]}, 32'h0);
      check("skip_mul_b", {28'h0, mb[d]}, 32'h0);
    end
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        check("stall_valid", {31'h0, ov[d]}, 32'h1);
        check("stall_out_p", {16'h0, op[d]}, {16'h0, p});
        check("stall_in_ready", {31'h0, ir[d]}, 32'h0);
        if (i == 2) begin
          iv[d] = 1'b1;
          ia[d] = 8'h55;
          ib[d] = 8'h66;
        end
        @(negedge clk);
      end
      check("stall_op_count", cnt_of(d), cnt_mask(d, exp_cnt[d]));
      @(posedge clk); #1;
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
    end
    @(posedge clk); #1;
    exp_cnt[d]++;
    check($sformatf("op_count_d%0d", d), cnt_of(d), cnt_mask(d, exp_cnt[d]));
    check($sformatf("in_ready_after_d%0d", d), {31'h0, ir[d]}, 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ia[d] = 8'h00; ib[d] = 8'h00; ordy[d] = 1'b1; exp_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'h0, ir[0]}, 32'h1);
    check("rst_out_valid", {31'h0, ov[0]}, 32'h0);
    check("rst_out_p", {16'h0, op[0]}, 32'h0);
    check("rst_mul", {24'h0, ma[0], mb[0]}, 32'h0);
    check("rst_busy", {31'h0, bsy[0]}, 32'h0);
    check("rst_op_count", cnt_of(0), 32'h0);

    // Reset in the middle of a calculation: no result, no count.
    @(posedge clk); #1;
    iv[0] = 1'b1; ia[0] = 8'h77; ib[0] = 8'h88;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", {31'h0, ir[0]}, 32'h1);
    check("midrst_busy", {31'h0, bsy[0]}, 32'h0);
    check("midrst_op_count", cnt_of(0), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", {31'h0, ov[0]}, 32'h0);
    end
    @(posedge clk); #1;
    run_op(0, 8'h02, 8'h03, 16'h0006, 5, 1'b0);

    run_op(0, 8'hFF, 8'hFF, 16'hFE01, 5, 1'b0);
    run_op(0, 8'hA3, 8'h5C, 16'h3A94, 5, 1'b0);
    run_op(0, 8'h12, 8'h34, 16'h03A8, 5, 1'b1);
    run_op(0, 8'h00, 8'h5A, 16'h0000, 1, 1'b0);
    run_op(0, 8'h5A, 8'h00, 16'h0000, 1, 1'b0);

    run_op(1, 8'h00, 8'h5A, 16'h0000, 5, 1'b0);
    run_op(1, 8'hA3, 8'h5C, 16'h3A94, 5, 1'b0);

    // Narrow counter wraps after sixteen completions.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'(i + 1);
      b = 8'(8'hF0 - i);
      run_op(2, a, b, 16'(a * b), 5, 1'b0);
      if (i == 14) check("wrap_cnt_F", cnt_of(2), 32'hF);
      if (i == 15) check("wrap_cnt_0", cnt_of(2), 32'h0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
